led_step_gen: RTL and testbench

Step-timing front end for the running-LED pattern generators. Produces a one-cycle `step` pulse at a user-selectable rate, with the rate chosen by debounced up/down push-buttons and a debounced pause toggle. Sits directly upstream of the LED pattern stage; that stage advances its pattern by exactly one position per `step` pulse.

---
 rtl/led_step_if.sv | 13 +
 rtl/led_step_gen.sv | 90 +++++++++
 tb/tb_led_step_gen.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/led_step_if.sv
// Button inputs and step/status outputs of the LED step generator.
// The slave modport is the generator; the master side drives the raw buttons.
interface led_step_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_pause;
    logic       step;
    logic [2:0] level;
    logic       paused;

    modport master (output btn_up, btn_down, btn_pause, input step, level, paused);
    modport slave  (input btn_up, btn_down, btn_pause, output step, level, paused);
endinterface

// File: rtl/led_step_gen.sv
// Debounced speed/pause buttons driving a prescaler that emits one-cycle step pulses.
// Step period is BASE_DIV >> level; a level change restarts the prescaler.
module led_step_gen #(
    parameter int BASE_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst,
    led_step_if.slave    bus
);
    localparam int PW = $clog2(BASE_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);

    // Button order in the vectors below: [0]=up, [1]=down, [2]=pause
    logic [2:0]    raw, s1, s2, db, db_q, press;
    logic [DW-1:0] dcnt [3];

    logic [2:0]    lvl, lvl_nx;
    logic          pause_r, pause_nx;
    logic          step_r;
    logic [PW-1:0] pcnt, period;

    assign raw = {bus.btn_pause, bus.btn_down, bus.btn_up};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_q <= '0;
            for (int i = 0; i < 3; i++) dcnt[i] <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            db_q <= db;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == db[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    db[i]   <= s2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    // Only the rising edge of the debounced state counts; releases are ignored.
    assign press = db & ~db_q;

    always_comb begin
        lvl_nx = lvl;
        if (press[0] && !press[1] && lvl != 3'd7)
            lvl_nx = lvl + 3'd1;
        else if (press[1] && !press[0] && lvl != 3'd0)
            lvl_nx = lvl - 3'd1;
        pause_nx = pause_r ^ press[2];
    end

    assign period = PW'(BASE_DIV) >> lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl     <= '0;
            pause_r <= 1'b0;
            pcnt    <= '0;
            step_r  <= 1'b0;
        end else begin
            lvl     <= lvl_nx;
            pause_r <= pause_nx;
            if (lvl_nx != lvl) begin
                pcnt   <= '0;
                step_r <= 1'b0;
            end else if (pause_r) begin
                step_r <= 1'b0;
            end else if (pcnt == period - PW'(1)) begin
                pcnt   <= '0;
                step_r <= 1'b1;
            end else begin
                pcnt   <= pcnt + PW'(1);
                step_r <= 1'b0;
            end
        end
    end

    assign bus.step   = step_r;
    assign bus.level  = lvl;
    assign bus.paused = pause_r;
endmodule

// File: tb/tb_led_step_gen.sv
// Directed bench for led_step_gen: press-table vectors plus timing sequences.
module tb_led_step_gen;
    localparam int BASE = 256;
    localparam int DEB  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    led_step_if bus();

    led_step_gen #(.BASE_DIV(BASE), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int step_cnt = 0;
    int dbl      = 0;
    int pcyc     = 0;
    logic step_q = 1'b0;

    always @(negedge clk) begin
        if (bus.step === 1'b1) begin
            step_cnt++;
            if (step_q) dbl++;
        end
        step_q = (bus.step === 1'b1);
        if (bus.paused === 1'b1) pcyc++;
    end

    typedef struct {
        logic up;
        logic dn;
        logic pz;
        int   exp_lvl;
        int   exp_pz;
    } vec_t;

    vec_t vecs[17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic press(input logic u, input logic d, input logic p);
        bus.btn_up = u; bus.btn_down = d; bus.btn_pause = p;
        repeat (10) tick();
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_pause = 1'b0;
        repeat (10) tick();
    endtask

    // Ticks until step is seen; returns tick count or -1 when the budget runs out.
    task automatic wait_step(input int maxc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.step !== 1'b1 && n < maxc);
        if (bus.step !== 1'b1) n = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, sc0, pc0, gap;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 3, 0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 3, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 2, 0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 2, 1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 3, 0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 3, 1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 2, 1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 2, 0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 3, 0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 4, 0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 5, 0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 6, 0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 7, 0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 7, 0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 6, 0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 7, 0};

        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_pause = 1'b0;

        // Reset and idle cadence at level 0
        repeat (2) tick();
        rst = 1'b0;
        chk("reset_level", int'(bus.level), 0);
        chk("reset_paused", int'(bus.paused), 0);
        chk("reset_step", int'(bus.step), 0);
        wait_step(400, n);
        chk("first_step_after_reset", n, BASE);
        wait_step(400, n);
        chk("idle_period", n, BASE);

        // Up press latency: level changes on the 7th tick counting the first sampling edge
        bus.btn_up = 1'b1;
        repeat (6) tick();
        chk("up_before_latency", int'(bus.level), 0);
        tick();
        chk("up_at_latency", int'(bus.level), 1);
        repeat (3) tick();
        bus.btn_up = 1'b0;
        wait_step(400, n);
        chk("first_step_level1", n, 125);
        wait_step(400, n);
        chk("period_level1", n, 128);

        foreach (vecs[i]) begin
            press(vecs[i].up, vecs[i].dn, vecs[i].pz);
            chk($sformatf("vec%0d_level", i), int'(bus.level), vecs[i].exp_lvl);
            chk($sformatf("vec%0d_paused", i), int'(bus.paused), vecs[i].exp_pz);
        end

        wait_step(100, n);
        wait_step(100, n);
        chk("period_level7", n, 2);

        // Down to the floor, then one more down must not restart the prescaler
        repeat (7) press(1'b0, 1'b1, 1'b0);
        chk("down_to_zero", int'(bus.level), 0);
        wait_step(600, n);
        press(1'b0, 1'b1, 1'b0);
        chk("down_sat_level", int'(bus.level), 0);
        wait_step(400, n);
        chk("down_sat_no_restart", n, BASE - 20);

        // Bouncing input, 2-cycle toggles, must be rejected
        wait_step(400, n);
        for (int k = 0; k < 5; k++) begin
            bus.btn_up = 1'b1; repeat (2) tick();
            bus.btn_up = 1'b0; repeat (2) tick();
        end
        repeat (10) tick();
        chk("bounce_level", int'(bus.level), 0);
        wait_step(400, n);
        chk("bounce_cadence", n, BASE - 30);

        // Simultaneous up/down at level 3 leaves cadence intact
        repeat (3) press(1'b1, 1'b0, 1'b0);
        chk("level3", int'(bus.level), 3);
        wait_step(100, n);
        bus.btn_up = 1'b1; bus.btn_down = 1'b1;
        repeat (10) tick();
        bus.btn_up = 1'b0; bus.btn_down = 1'b0;
        repeat (10) tick();
        chk("updown_level", int'(bus.level), 3);
        wait_step(100, n);
        chk("updown_cadence", n, 12);

        // Pause mid-count: gap across the pause is P plus paused cycles
        repeat (3) press(1'b0, 1'b1, 1'b0);
        wait_step(600, n);
        repeat (100) tick();
        sc0 = step_cnt;
        pc0 = pcyc;
        press(1'b0, 1'b0, 1'b1);
        repeat (480) tick();
        chk("paused_high", int'(bus.paused), 1);
        press(1'b0, 1'b0, 1'b1);
        chk("paused_low", int'(bus.paused), 0);
        chk("no_steps_while_paused", step_cnt - sc0, 0);
        wait_step(400, n);
        gap = 100 + 20 + 480 + 20 + n;
        chk("pause_gap", gap, BASE + (pcyc - pc0));

        // Reset while paused at level 5 with up held through reset
        repeat (5) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk("pre_reset_level", int'(bus.level), 5);
        chk("pre_reset_paused", int'(bus.paused), 1);
        bus.btn_up = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_level", int'(bus.level), 0);
        chk("midrst_paused", int'(bus.paused), 0);
        chk("midrst_step", int'(bus.step), 0);
        repeat (6) tick();
        chk("post_rst_before_latency", int'(bus.level), 0);
        tick();
        chk("post_rst_level", int'(bus.level), 1);
        bus.btn_up = 1'b0;
        repeat (20) tick();
        chk("post_rst_single_press", int'(bus.level), 1);

        chk("step_single_cycle", dbl, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
